cc_line_fill_engine: RTL and testbench
======================================

// Module: cc_line_fill_engine
// PURPOSE
//  Parametrised cache-line fill engine between the AXI R channel and the cache SRAM write port.
//  - Pops the pending miss address from the miss-addr FIFO on the first R beat of each fill.
//  - Assembles DATA_W beats into one line, critical-word-first with wrap.
//  - Issues a single-cycle SRAM write of tag and data.
//  - Owns rready, and flags R-burst length violations.
// PARAMETERS
//  DATA_W      64   R-channel beat width (bits); power of 2, >= 8
//  LINE_BYTES  64   cache line size (bytes); LINE_BYTES*8 is a multiple of DATA_W
//  ADDR_W      32   miss address width
//  INDEX_W     9    SRAM set-index width
//  derived: BEATS=LINE_BYTES*8/DATA_W; OFF_W=$clog2(LINE_BYTES); BOFF_W=$clog2(DATA_W/8)
//           TAG_W=ADDR_W-INDEX_W-OFF_W (17 at defaults)
// PORTS
//  clk                     in   1               clock
//  rst_n                   in   1               synchronous reset, active low
//  mem_rdata_i             in   DATA_W          R beat data
//  mem_rlast_i             in   1               R last beat
//  mem_rvalid_i            in   1               R valid
//  mem_rready_o            out  1               R ready
//  miss_addr_fifo_empty_i  in   1               miss FIFO empty
//  miss_addr_fifo_rdata_i  in   ADDR_W          miss FIFO head (show-ahead)
//  miss_addr_fifo_rden_o   out  1               miss FIFO pop (combinational)
//  wren_o                  out  1               SRAM write enable
//  waddr_o                 out  INDEX_W         SRAM set index
//  wdata_tag_o             out  TAG_W+1         {valid, tag}
//  wdata_data_o            out  LINE_BYTES*8    line data
//  fill_err_o              out  1               sticky burst-length error
//  crit_valid_o            out  1               critical word valid (see CONFIGURATION)
//  crit_data_o             out  DATA_W          critical word
// BEHAVIOUR
//  Reset: state=IDLE; beat counter=0; line buffer=0; all outputs 0.
//  Handshake: a beat is accepted when mem_rvalid_i & mem_rready_o. Held-off beats are never lost.
//  mem_rready_o = (state==FILL) | (state==IDLE & !miss_addr_fifo_empty_i); 0 in WRITE.
//  IDLE:
//   - On an accepted beat: miss_addr_fifo_rden_o=1 in the same cycle.
//   - Capture index=addr[OFF_W+INDEX_W-1:OFF_W], tag=addr[ADDR_W-1:OFF_W+INDEX_W], start=addr[OFF_W-1:BOFF_W].
//   - Store beat 0; cnt<=1; go to FILL.
//   - If BEATS==1: go straight to WRITE.
//  FILL: each accepted beat k is stored at slot (start+k) mod BEATS, bits [slot*DATA_W +: DATA_W]; cnt<=cnt+1.
//  Beat counts:
//   - Final beat (cnt==BEATS-1) with rlast=1: normal end; go to WRITE, valid=1.
//   - Final beat with rlast=0: set fill_err_o; valid=0; go to WRITE.
//     The surplus beats of that burst are then accepted in IDLE as a new fill, which is undefined.
//   - Accepted beat with rlast=1 and cnt<BEATS-1 (early): set fill_err_o; valid=0; go to WRITE.
//     Unfilled slots keep stale contents.
//  WRITE (exactly 1 cycle):
//   - wren_o=1; waddr_o/wdata_tag_o/wdata_data_o are stable this cycle.
//   - Next state is IDLE; cnt<=0. wren_o=0 in every other state.
//  Latency: wren_o asserts the cycle after the last accepted beat. Back-to-back fills lose exactly 1 cycle (WRITE bubble).
//  miss_addr_fifo_rden_o is never asserted when miss_addr_fifo_empty_i=1. It is never asserted outside IDLE.
//  fill_err_o clears only on reset.
//  Reset mid-fill aborts the fill: no write, no further pop. The partial burst is dropped.
//  Counter width: $clog2(BEATS)+1. Slot arithmetic is modulo BEATS, with no overflow.
// CONFIGURATION
//  Macro: CC_FILL_CRIT_FWD_EN.
//   Defined: one cycle after the first beat of each fill is accepted, crit_valid_o=1 for one cycle.
//   In that cycle crit_data_o = that beat, which is the requested critical word.
//   Undefined: crit_valid_o and crit_data_o are tied to 0, and no forwarding register is built.
// TESTING
//  1. Defaults, FIFO head 0x0001_2348 (start=1), 8 beats D0..D7 with rlast on D7
//     -> rden pulses with D0; D0 lands in slot 1 and D7 in slot 0.
//     -> wren=1 the cycle after D7; waddr=0x08D; tag={1,0x00002}; err=0.
//  2. rvalid held high with FIFO empty -> rready=0, no handshake, no rden.
//     FIFO goes non-empty -> the fill proceeds as in test 1.
//  3. Two back-to-back bursts with 2 FIFO entries -> two rden pulses, two wren pulses.
//     rready=0 only in each WRITE cycle; no beat is dropped.
//  4. Early rlast on beat 4 (cnt=4) -> wren next cycle, valid bit 0, fill_err_o=1 and stays set.
//  5. Reset asserted after beat 3 -> no wren; outputs 0; the next full burst fills correctly.
//  6. DATA_W=128, LINE_BYTES=64 (BEATS=4), start=3 -> beats land in slots 3,0,1,2.
//     With CC_FILL_CRIT_FWD_EN: crit_valid_o=1 with the beat-0 data, one cycle after its handshake.

Source files
------------

// File: rtl/cc_line_fill_engine_if.sv
// R-channel, miss-address FIFO and SRAM write-port signals of cc_line_fill_engine.
// master = the fill engine, slave = the surrounding memory system.
interface cc_line_fill_engine_if #(
  parameter int DATA_W     = 64,
  parameter int LINE_BYTES = 64,
  parameter int ADDR_W     = 32,
  parameter int INDEX_W    = 9
);
  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int TAG_W = ADDR_W - INDEX_W - OFF_W;

  logic [DATA_W-1:0]       mem_rdata_i;
  logic                    mem_rlast_i;
  logic                    mem_rvalid_i;
  logic                    mem_rready_o;
  logic                    miss_addr_fifo_empty_i;
  logic [ADDR_W-1:0]       miss_addr_fifo_rdata_i;
  logic                    miss_addr_fifo_rden_o;
  logic                    wren_o;
  logic [INDEX_W-1:0]      waddr_o;
  logic [TAG_W:0]          wdata_tag_o;
  logic [LINE_BYTES*8-1:0] wdata_data_o;
  logic                    fill_err_o;
  logic                    crit_valid_o;
  logic [DATA_W-1:0]       crit_data_o;

  modport master (
    input  mem_rdata_i, mem_rlast_i, mem_rvalid_i,
    input  miss_addr_fifo_empty_i, miss_addr_fifo_rdata_i,
    output mem_rready_o, miss_addr_fifo_rden_o,
    output wren_o, waddr_o, wdata_tag_o, wdata_data_o,
    output fill_err_o, crit_valid_o, crit_data_o
  );

  modport slave (
    output mem_rdata_i, mem_rlast_i, mem_rvalid_i,
    output miss_addr_fifo_empty_i, miss_addr_fifo_rdata_i,
    input  mem_rready_o, miss_addr_fifo_rden_o,
    input  wren_o, waddr_o, wdata_tag_o, wdata_data_o,
    input  fill_err_o, crit_valid_o, crit_data_o
  );
endinterface

// File: rtl/cc_line_fill_engine.sv
// Cache-line fill engine: gathers R beats critical-word-first into a line, then one SRAM write.
// Optional critical-word forwarding register is built only with CC_FILL_CRIT_FWD_EN defined.
module cc_line_fill_engine #(
  parameter int DATA_W     = 64,
  parameter int LINE_BYTES = 64,
  parameter int ADDR_W     = 32,
  parameter int INDEX_W    = 9
) (
  input logic                   clk,
  input logic                   rst_n,
  cc_line_fill_engine_if.master bus
);
  localparam int BEATS  = LINE_BYTES * 8 / DATA_W;
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int BOFF_W = $clog2(DATA_W / 8);
  localparam int TAG_W  = ADDR_W - INDEX_W - OFF_W;
  localparam int LINE_W = LINE_BYTES * 8;
  localparam int CNT_W  = $clog2(BEATS) + 1;
  localparam int SLOT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [SLOT_W-1:0]  start_q;
  logic [INDEX_W-1:0] index_q;
  logic [TAG_W-1:0]   tag_q;
  logic               valid_q;
  logic               wren_q;
  logic               err_q;
  logic [LINE_W-1:0]  line_q;

  logic               accept;
  logic               first_beat;
  logic               fill_end;
  logic               fill_ok;
  logic [CNT_W-1:0]   beat_idx;
  logic [SLOT_W-1:0]  head_start;
  logic [SLOT_W-1:0]  start_sel;
  logic [SLOT_W-1:0]  slot;
  logic [INDEX_W-1:0] head_index;
  logic [TAG_W-1:0]   head_tag;

  assign bus.mem_rready_o = (state_q == FILL) |
                            ((state_q == IDLE) & ~bus.miss_addr_fifo_empty_i);
  assign accept           = bus.mem_rvalid_i & bus.mem_rready_o;
  assign first_beat       = accept & (state_q == IDLE);
  assign bus.miss_addr_fifo_rden_o = first_beat;

  // Field extraction via shifts keeps BEATS==1 legal (empty beat-offset field).
  assign head_start = SLOT_W'((bus.miss_addr_fifo_rdata_i >> BOFF_W) % BEATS);
  assign head_index = INDEX_W'(bus.miss_addr_fifo_rdata_i >> OFF_W);
  assign head_tag   = TAG_W'(bus.miss_addr_fifo_rdata_i >> (OFF_W + INDEX_W));

  assign beat_idx  = (state_q == IDLE) ? '0 : cnt_q;
  assign start_sel = (state_q == IDLE) ? head_start : start_q;
  assign slot      = SLOT_W'((int'(start_sel) + int'(beat_idx)) % BEATS);
  assign fill_end  = accept & ((int'(beat_idx) == BEATS - 1) | bus.mem_rlast_i);
  assign fill_ok   = (int'(beat_idx) == BEATS - 1) & bus.mem_rlast_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      start_q <= '0;
      index_q <= '0;
      tag_q   <= '0;
      valid_q <= 1'b0;
      wren_q  <= 1'b0;
      err_q   <= 1'b0;
      line_q  <= '0;
    end else begin
      wren_q <= 1'b0;
      if (accept) line_q[int'(slot)*DATA_W +: DATA_W] <= bus.mem_rdata_i;
      case (state_q)
        IDLE: begin
          if (first_beat) begin
            index_q <= head_index;
            tag_q   <= head_tag;
            start_q <= head_start;
            cnt_q   <= CNT_W'(1);
            if (fill_end) begin
              state_q <= WRITE;
              wren_q  <= 1'b1;
              valid_q <= fill_ok;
              err_q   <= err_q | ~fill_ok;
            end else begin
              state_q <= FILL;
            end
          end
        end
        FILL: begin
          if (accept) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (fill_end) begin
              state_q <= WRITE;
              wren_q  <= 1'b1;
              valid_q <= fill_ok;
              err_q   <= err_q | ~fill_ok;
            end
          end
        end
        WRITE: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.wren_o       = wren_q;
  assign bus.waddr_o      = index_q;
  assign bus.wdata_tag_o  = {valid_q, tag_q};
  assign bus.wdata_data_o = line_q;
  assign bus.fill_err_o   = err_q;

`ifdef CC_FILL_CRIT_FWD_EN
  logic              crit_valid_q;
  logic [DATA_W-1:0] crit_data_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      crit_valid_q <= 1'b0;
      crit_data_q  <= '0;
    end else begin
      crit_valid_q <= first_beat;
      if (first_beat) crit_data_q <= bus.mem_rdata_i;
    end
  end

  assign bus.crit_valid_o = crit_valid_q;
  assign bus.crit_data_o  = crit_data_q;
`else
  assign bus.crit_valid_o = 1'b0;
  assign bus.crit_data_o  = '0;
`endif
endmodule

// File: tb/tb_cc_line_fill_engine.sv
// Randomised bench for cc_line_fill_engine: line-level scoreboard plus directed literal checks,
// and a second 128-bit-beat instance for the 4-beat wrap case.
module tb_cc_line_fill_engine;
  localparam int DW     = 64;
  localparam int LB     = 64;
  localparam int AW     = 32;
  localparam int IW     = 9;
  localparam int BEATS  = LB * 8 / DW;
  localparam int OFF_W  = $clog2(LB);
  localparam int BOFF_W = $clog2(DW / 8);
  localparam int TW     = AW - IW - OFF_W;
  localparam int LW     = LB * 8;
  localparam int DW2    = 128;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cc_line_fill_engine_if #(.DATA_W(DW),  .LINE_BYTES(LB), .ADDR_W(AW), .INDEX_W(IW)) bus ();
  cc_line_fill_engine_if #(.DATA_W(DW2), .LINE_BYTES(LB), .ADDR_W(AW), .INDEX_W(IW)) bus2 ();

  cc_line_fill_engine #(.DATA_W(DW), .LINE_BYTES(LB), .ADDR_W(AW), .INDEX_W(IW)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  cc_line_fill_engine #(.DATA_W(DW2), .LINE_BYTES(LB), .ADDR_W(AW), .INDEX_W(IW)) u_dut_wide (
    .clk(clk), .rst_n(rst_n), .bus(bus2));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Environment FIFO (what the DUT pops) and the model's own copy of the pending addresses.
  logic [AW-1:0] fifo_q[$];
  logic [AW-1:0] exp_q[$];
  logic          pop_req = 1'b0;

  function automatic void fifo_refresh();
    bus.miss_addr_fifo_empty_i = (fifo_q.size() == 0);
    bus.miss_addr_fifo_rdata_i = (fifo_q.size() == 0) ? '0 : fifo_q[0];
  endfunction

  task automatic push_addr(input logic [AW-1:0] a);
    fifo_q.push_back(a);
    exp_q.push_back(a);
    fifo_refresh();
  endtask

  always @(posedge clk) begin
    #1;
    if (pop_req && fifo_q.size() > 0) void'(fifo_q.pop_front());
    fifo_refresh();
  end

  // Line-level model state.
  int             k = 0;
  int             m_start = 0;
  logic [IW-1:0]  m_index = '0;
  logic [TW-1:0]  m_tag = '0;
  logic           m_valid = 1'b0;
  logic           m_err = 1'b0;
  logic           wr_pend = 1'b0;
  logic [LW-1:0]  m_line = '0;
  logic           crit_pend = 1'b0;
  logic [DW-1:0]  crit_exp = '0;
  int             rden_cnt = 0;
  int             wr_cnt = 0;
  logic [IW-1:0]  last_waddr = '0;
  logic [TW:0]    last_tag = '0;
  logic [LW-1:0]  last_data = '0;
  logic [DW-1:0]  bdat[16];

  always @(negedge clk) begin : mon
    logic          rdy;
    logic          acc;
    logic [AW-1:0] a;
    int            slot;
    if (!rst_n) begin
      k = 0; wr_pend = 1'b0; crit_pend = 1'b0; m_line = '0; m_err = 1'b0; pop_req = 1'b0;
    end else begin
      if (bus.wren_o) wr_cnt++;
      if (bus.miss_addr_fifo_rden_o) rden_cnt++;
      chk("wren", bus.wren_o, wr_pend);
      if (wr_pend) begin
        chk("waddr", bus.waddr_o, m_index);
        chk("wtag", bus.wdata_tag_o, {m_valid, m_tag});
        chk("wdata", bus.wdata_data_o, m_line);
        last_waddr = bus.waddr_o;
        last_tag   = bus.wdata_tag_o;
        last_data  = bus.wdata_data_o;
      end
      chk("fill_err", bus.fill_err_o, m_err);
`ifdef CC_FILL_CRIT_FWD_EN
      chk("crit_valid", bus.crit_valid_o, crit_pend);
      if (crit_pend) chk("crit_data", bus.crit_data_o, crit_exp);
`else
      chk("crit_valid", bus.crit_valid_o, 1'b0);
      chk("crit_data", bus.crit_data_o, '0);
`endif
      rdy = !wr_pend && (k > 0 || exp_q.size() > 0);
      acc = bus.mem_rvalid_i && rdy;
      chk("rready", bus.mem_rready_o, rdy);
      chk("rden", bus.miss_addr_fifo_rden_o, acc && (k == 0));
      pop_req   = bus.miss_addr_fifo_rden_o;
      crit_pend = 1'b0;
      wr_pend   = 1'b0;
      if (acc) begin
        if (k == 0) begin
          a         = exp_q.pop_front();
          m_start   = int'((a >> BOFF_W) % BEATS);
          m_index   = a[OFF_W +: IW];
          m_tag     = a[OFF_W+IW +: TW];
          crit_pend = 1'b1;
          crit_exp  = bus.mem_rdata_i;
        end
        slot = (m_start + k) % BEATS;
        m_line[slot*DW +: DW] = bus.mem_rdata_i;
        k++;
        if (k == BEATS || bus.mem_rlast_i) begin
          m_valid = (k == BEATS) && bus.mem_rlast_i;
          m_err   = m_err | !m_valid;
          wr_pend = 1'b1;
          k       = 0;
        end
      end
    end
  end

  // Called and returns at posedge+1; holds the beat until the DUT takes it.
  task automatic send_beat(input logic [DW-1:0] d, input logic last);
    logic got;
    int   waited;
    got = 1'b0;
    waited = 0;
    bus.mem_rdata_i  = d;
    bus.mem_rlast_i  = last;
    bus.mem_rvalid_i = 1'b1;
    while (!got && waited < 200) begin
      @(negedge clk);
      got = bus.mem_rready_o;
      @(posedge clk);
      #1;
      waited++;
    end
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rlast_i  = 1'b0;
    chk("beat_accept", got, 1'b1);
  endtask

  task automatic send_burst(input int n, input int last_at, input int max_gap);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(max_gap, 0)) begin @(posedge clk); #1; end
      send_beat(bdat[i], i == last_at);
    end
    @(negedge clk);
    #1;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < 16; i++) bdat[i] = {$urandom, $urandom};
  endtask

  task automatic run_wide();
    logic [DW2-1:0] e[4];
    for (int b = 0; b < 4; b++) e[b] = {$urandom, $urandom, $urandom, $urandom};
    bus2.miss_addr_fifo_rdata_i = 32'h0004_0070;
    bus2.miss_addr_fifo_empty_i = 1'b0;
    for (int b = 0; b < 4; b++) begin
      bus2.mem_rvalid_i = 1'b1;
      bus2.mem_rdata_i  = e[b];
      bus2.mem_rlast_i  = (b == 3);
      @(negedge clk);
      chk("w_rready", bus2.mem_rready_o, 1'b1);
      chk("w_rden", bus2.miss_addr_fifo_rden_o, b == 0);
`ifdef CC_FILL_CRIT_FWD_EN
      if (b == 1) begin
        chk("w_crit_valid", bus2.crit_valid_o, 1'b1);
        chk("w_crit_data", bus2.crit_data_o, e[0]);
      end
`else
      chk("w_crit_valid", bus2.crit_valid_o, 1'b0);
`endif
      @(posedge clk);
      #1;
      if (b == 0) bus2.miss_addr_fifo_empty_i = 1'b1;
    end
    bus2.mem_rvalid_i = 1'b0;
    bus2.mem_rlast_i  = 1'b0;
    @(negedge clk);
    chk("w_wren", bus2.wren_o, 1'b1);
    chk("w_waddr", bus2.waddr_o, 9'h001);
    chk("w_tag", bus2.wdata_tag_o, 18'h20008);
    chk("w_slot3", bus2.wdata_data_o[511:384], e[0]);
    chk("w_slot0", bus2.wdata_data_o[127:0], e[1]);
    chk("w_slot1", bus2.wdata_data_o[255:128], e[2]);
    chk("w_slot2", bus2.wdata_data_o[383:256], e[3]);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int r0;
    int w0;
    bus.mem_rdata_i = '0;  bus.mem_rlast_i = 1'b0;  bus.mem_rvalid_i = 1'b0;
    bus2.mem_rdata_i = '0; bus2.mem_rlast_i = 1'b0; bus2.mem_rvalid_i = 1'b0;
    bus2.miss_addr_fifo_empty_i = 1'b1;
    bus2.miss_addr_fifo_rdata_i = '0;
    fifo_refresh();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    @(negedge clk);
    chk("rst_wren", bus.wren_o, 1'b0);
    chk("rst_waddr", bus.waddr_o, '0);
    chk("rst_tag", bus.wdata_tag_o, '0);
    chk("rst_data", bus.wdata_data_o, '0);
    chk("rst_err", bus.fill_err_o, 1'b0);
    chk("rst_crit", bus.crit_valid_o, 1'b0);
    chk("rst_wren_wide", bus2.wren_o, 1'b0);
    @(posedge clk);
    #1;

    // Critical-word-first fill, start slot 1.
    for (int i = 0; i < 8; i++) bdat[i] = 64'hD0D0_0000_0000_0000 | 64'(i);
    r0 = rden_cnt; w0 = wr_cnt;
    push_addr(32'h0001_2348);
    send_burst(8, 7, 0);
    chk("t1_waddr", last_waddr, 9'h08D);
    chk("t1_tag", last_tag, 18'h20002);
    chk("t1_slot1", last_data[127:64], bdat[0]);
    chk("t1_slot0", last_data[63:0], bdat[7]);
    chk("t1_err", bus.fill_err_o, 1'b0);
    chk("t1_rden_pulses", rden_cnt - r0, 1);
    chk("t1_wren_pulses", wr_cnt - w0, 1);

    // rvalid held while FIFO empty.
    rand_data();
    r0 = rden_cnt;
    bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = bdat[0]; bus.mem_rlast_i = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    chk("t2_no_rden", rden_cnt, r0);
    chk("t2_rready", bus.mem_rready_o, 1'b0);
    push_addr(32'h0001_2348);
    send_burst(8, 7, 0);
    chk("t2_rden", rden_cnt - r0, 1);
    chk("t2_slot1", last_data[127:64], bdat[0]);

    run_wide();

    // Back-to-back bursts, second starting at slot 0.
    rand_data();
    r0 = rden_cnt; w0 = wr_cnt;
    push_addr(32'h0001_2348);
    push_addr(32'hABCD_E1C0);
    for (int i = 0; i < 16; i++) send_beat(bdat[i], (i % 8) == 7);
    @(negedge clk); #1; @(posedge clk); #1;
    chk("t3_rden_pulses", rden_cnt - r0, 2);
    chk("t3_wren_pulses", wr_cnt - w0, 2);
    chk("t3_slot0", last_data[63:0], bdat[8]);
    chk("t3_slot7", last_data[511:448], bdat[15]);

    // Reset in the middle of a fill.
    rand_data();
    w0 = wr_cnt;
    push_addr($urandom);
    for (int i = 0; i < 4; i++) send_beat(bdat[i], 1'b0);
    rst_n = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_wren", bus.wren_o, 1'b0);
    chk("t5_data", bus.wdata_data_o, '0);
    chk("t5_tag", bus.wdata_tag_o, '0);
    chk("t5_no_write", wr_cnt, w0);
    @(posedge clk);
    #1;
    rand_data();
    push_addr(32'h0000_0040);
    send_burst(8, 7, 1);
    chk("t5_refill", last_data[63:0], bdat[0]);

    for (int n = 0; n < 20; n++) begin
      rand_data();
      push_addr($urandom);
      send_burst(8, 7, 2);
    end

    // Early rlast with cnt=4.
    rand_data();
    push_addr($urandom);
    send_burst(5, 4, 0);
    chk("t4_valid", last_tag[TW], 1'b0);
    chk("t4_err", bus.fill_err_o, 1'b1);

    for (int n = 0; n < 15; n++) begin
      int len;
      len = $urandom_range(8, 2);
      rand_data();
      push_addr($urandom);
      send_burst(len, len - 1, 2);
    end
    chk("t4_err_sticky", bus.fill_err_o, 1'b1);

    // Burst with no rlast on the final beat.
    rand_data();
    push_addr($urandom);
    send_burst(8, -1, 1);
    chk("long_valid", last_tag[TW], 1'b0);
    chk("long_err", bus.fill_err_o, 1'b1);
    chk("long_rready", bus.mem_rready_o, 1'b0);

    rst_n = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    @(negedge clk);
    chk("err_cleared", bus.fill_err_o, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
